// File: rtl/vga_timing_box.sv
// 640x480 VGA pixel-timing generator with a square "box" selection output for the colour stage.
// Define VGA_BOX_BOUNCE_EN to make the box bounce around the visible area, moving one step per frame.
module vga_timing_box #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int BOX_X0   = 288,
    parameter int BOX_Y0   = 208,
    parameter int BOX_SIZE = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       display_en,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start,
    output logic       Seleccion_color
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] BOX_SZ   = 11'(BOX_SIZE);

    if (BOX_X0 + BOX_SIZE > H_ACTIVE) begin : g_bad_box_x
        $error("vga_timing_box: BOX_X0 + BOX_SIZE exceeds H_ACTIVE");
    end
    if (BOX_Y0 + BOX_SIZE > V_ACTIVE) begin : g_bad_box_y
        $error("vga_timing_box: BOX_Y0 + BOX_SIZE exceeds V_ACTIVE");
    end

    logic [9:0]  h_cnt, v_cnt;
    logic [9:0]  box_x, box_y;
    logic        h_wrap, frame_wrap;
    logic [10:0] h_ext, v_ext, bx_ext, by_ext;
    logic        active, in_box, hs_n, vs_n;

    assign h_wrap     = (h_cnt == H_LAST);
    assign frame_wrap = h_wrap && (v_cnt == V_LAST);
    assign h_ext      = {1'b0, h_cnt};
    assign v_ext      = {1'b0, v_cnt};
    assign bx_ext     = {1'b0, box_x};
    assign by_ext     = {1'b0, box_y};

    // Decode of the current counter position; widened so box_x + BOX_SIZE cannot overflow.
    always_comb begin
        active = (h_ext < H_ACT) && (v_ext < V_ACT);
        in_box = active
                 && (h_ext >= bx_ext) && (h_ext < bx_ext + BOX_SZ)
                 && (v_ext >= by_ext) && (v_ext < by_ext + BOX_SZ);
        hs_n   = !((h_ext >= HS_START) && (h_ext < HS_END));
        vs_n   = !((v_ext >= VS_START) && (v_ext < VS_END));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Outputs describe the counter position one cycle late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync           <= 1'b1;
            vsync           <= 1'b1;
            display_en      <= 1'b0;
            pixel_x         <= '0;
            pixel_y         <= '0;
            frame_start     <= 1'b0;
            Seleccion_color <= 1'b0;
        end else begin
            hsync           <= hs_n;
            vsync           <= vs_n;
            display_en      <= active;
            pixel_x         <= h_cnt;
            pixel_y         <= v_cnt;
            frame_start     <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
            Seleccion_color <= in_box;
        end
    end

`ifdef VGA_BOX_BOUNCE_EN
    logic dx, dy;

    // Box moves only on the last-pixel-of-frame edge, so a whole frame sees one position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_x <= 10'(BOX_X0);
            box_y <= 10'(BOX_Y0);
            dx    <= 1'b1;
            dy    <= 1'b1;
        end else if (frame_wrap) begin
            if (dx && (bx_ext + BOX_SZ == H_ACT)) begin
                dx    <= 1'b0;
                box_x <= box_x - 10'd1;
            end else if (!dx && (box_x == 10'd0)) begin
                dx    <= 1'b1;
                box_x <= box_x + 10'd1;
            end else begin
                box_x <= dx ? box_x + 10'd1 : box_x - 10'd1;
            end

            if (dy && (by_ext + BOX_SZ == V_ACT)) begin
                dy    <= 1'b0;
                box_y <= box_y - 10'd1;
            end else if (!dy && (box_y == 10'd0)) begin
                dy    <= 1'b1;
                box_y <= box_y + 10'd1;
            end else begin
                box_y <= dy ? box_y + 10'd1 : box_y - 10'd1;
            end
        end
    end
`else
    assign box_x = 10'(BOX_X0);
    assign box_y = 10'(BOX_Y0);
`endif

endmodule

// File: tb/tb_vga_timing_box.sv
// Self-checking bench for vga_timing_box using a shrunken raster so several frames fit in a short run.
// Expected outputs come from a pixel-index model: cycle n after release maps directly to (frame, h, v).
module tb_vga_timing_box;

    localparam int HA = 40, HF = 4, HS = 8, HB = 4;
    localparam int VA = 30, VF = 2, VS = 2, VB = 3;
    localparam int BX0 = 30, BY0 = 20, BS = 8;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    localparam logic [24:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hsync, vsync, display_en, frame_start, Seleccion_color;
    logic [9:0] pixel_x, pixel_y;
    logic [24:0] obs_vec;

    int tests = 0;
    int failures = 0;
    int n = 0;

    vga_timing_box #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .BOX_X0(BX0), .BOX_Y0(BY0), .BOX_SIZE(BS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hsync(hsync),
        .vsync(vsync),
        .display_en(display_en),
        .pixel_x(pixel_x),
        .pixel_y(pixel_y),
        .frame_start(frame_start),
        .Seleccion_color(Seleccion_color)
    );

    always #5 clk = ~clk;

    assign obs_vec = {hsync, vsync, display_en, frame_start, Seleccion_color, pixel_x, pixel_y};

    // Box position in a given frame, stepping the bounce rule once per elapsed frame.
    function automatic void box_at(input int frame, output int bx, output int by);
        int ddx, ddy;
        bx  = BX0;
        by  = BY0;
        ddx = 1;
        ddy = 1;
`ifdef VGA_BOX_BOUNCE_EN
        for (int f = 0; f < frame; f++) begin
            if (ddx > 0 && bx + BS == HA) begin ddx = -1; bx = bx - 1; end
            else if (ddx < 0 && bx == 0) begin ddx = 1; bx = bx + 1; end
            else bx = bx + ddx;
            if (ddy > 0 && by + BS == VA) begin ddy = -1; by = by - 1; end
            else if (ddy < 0 && by == 0) begin ddy = 1; by = by + 1; end
            else by = by + ddy;
        end
`endif
    endfunction

    function automatic logic [24:0] model(input int idx);
        int frame, p, h, v, bx, by;
        logic hs, vs, de, fs, sel;
        frame = idx / FRAME;
        p     = idx % FRAME;
        h     = p % HT;
        v     = p / HT;
        box_at(frame, bx, by);
        de  = (h < HA) && (v < VA);
        hs  = !(h >= HA + HF && h < HA + HF + HS);
        vs  = !(v >= VA + VF && v < VA + VF + VS);
        fs  = (p == 0);
        sel = de && h >= bx && h < bx + BS && v >= by && v < by + BS;
        return {hs, vs, de, fs, sel, 10'(h), 10'(v)};
    endfunction

    task automatic check_output(input string tag, input logic [24:0] obs, input logic [24:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed hs,vs,de,fs,sel=%b%b%b%b%b x=%0d y=%0d expected %b%b%b%b%b x=%0d y=%0d",
                   tag, obs[24], obs[23], obs[22], obs[21], obs[20], obs[19:10], obs[9:0],
                   exp[24], exp[23], exp[22], exp[21], exp[20], exp[19:10], exp[9:0]);
        end
    endtask

    task automatic apply_stimulus(input int count);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            check_output($sformatf("pix%0d", n), obs_vec, model(n));
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_hold", obs_vec, RESET_VEC);

        rst_n = 1'b1;
        n = 0;
        apply_stimulus(3 * FRAME + int'($urandom_range(0, HT)));

        // Asynchronous reset at random points mid-frame, then a full restart from (0,0).
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(int'($urandom_range(100, FRAME - 1)));
            @(posedge clk);
            #2 rst_n = 1'b0;
            #1 check_output($sformatf("async_reset%0d", k), obs_vec, RESET_VEC);
            repeat (int'($urandom_range(1, 4))) begin
                @(negedge clk);
                check_output($sformatf("reset_held%0d", k), obs_vec, RESET_VEC);
            end
            rst_n = 1'b1;
            n = 0;
            apply_stimulus(FRAME + 50);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
